regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-read-port integer register file for the RISC-V datapath.
//   Adds three things to the basic file:
//   - optional write-to-read bypass
//   - a handshaked debug read/write port
//   - a multi-cycle clear engine that zeroes the file without asserting reset
//   Register 0 is hardwired to zero. Sits between decode (reads) and writeback (write).
// PARAMETERS
//   XLEN    32  data width of each register
//   NREGS   32  register count; power of two, >=4; AW = $clog2(NREGS)
//   NUM_RD  2   read ports, 1..4
//   BYPASS  1   1: same-cycle write data forwarded to matching read ports; 0: none
// PORTS
//   clk        in   1            clock; all state updates on rising edge
//   reset      in   1            asynchronous, active-high reset
//   rs_addr    in   NUM_RD*AW    read addresses; port i = [i*AW +: AW]
//   rs_data    out  NUM_RD*XLEN  read data (combinational); port i = [i*XLEN +: XLEN]
//   we         in   1            core write enable
//   rd         in   AW           core write address
//   wd         in   XLEN         core write data
//   dbg_req    in   1            debug access request
//   dbg_we     in   1            debug access is a write
//   dbg_addr   in   AW           debug register address
//   dbg_wdata  in   XLEN         debug write data
//   dbg_ack    out  1            one-cycle acknowledge
//   dbg_rdata  out  XLEN         debug read data, valid while dbg_ack=1
//   clr_req    in   1            start clear sequence
//   clr_busy   out  1            clear in progress; core must stall
// BEHAVIOUR
//   Reset (async, reset=1): all registers 0, FSM=IDLE, clr_ptr=1, dbg_ack=0,
//     dbg_rdata=0, clr_busy=0. Because registers are 0, rs_data is all zero.
//   Read ports: combinational.
//     - rs_addr_i==0 -> 0.
//     - Else if BYPASS && write_eff && rd==rs_addr_i -> wd.
//     - Else register[rs_addr_i].
//     - write_eff = we && rd!=0 && state!=CLEAR.
//   Core write: at the clock edge when write_eff=1, register[rd] <= wd.
//     Writes to r0 are dropped. Writes during CLEAR are dropped.
//   FSM states: IDLE, CLEAR, ACK.
//   IDLE:
//     - clr_req=1 -> CLEAR, clr_ptr<=1. clr_req has priority over dbg_req.
//     - Else dbg_req=1 -> accept, go to ACK. At the accepting edge:
//       - dbg_rdata <= register[dbg_addr], the pre-write value (0 for r0).
//       - If dbg_we && dbg_addr!=0: register[dbg_addr] <= dbg_wdata, unless
//         write_eff && rd==dbg_addr, in which case the core write wins and the
//         debug write is dropped.
//       - Bypass does not apply to dbg_rdata.
//   ACK:
//     - dbg_ack=1 for exactly one cycle, then IDLE unconditionally.
//     - Requester drops dbg_req during ACK. dbg_req still high in the next IDLE
//       cycle starts a new access.
//     - clr_req during ACK is ignored; the requester holds it.
//     - dbg_rdata holds its value until the next accepted access.
//   CLEAR:
//     - clr_busy=1.
//     - Each cycle register[clr_ptr] <= 0 and clr_ptr++.
//     - At clr_ptr==NREGS-1 that register is cleared, then -> IDLE, clr_ptr<=1.
//     - Duration is NREGS-1 cycles. clr_busy falls the cycle after the last clear.
//     - Reads during CLEAR return current contents, a mix of cleared and old values.
//     - dbg_req and clr_req are ignored during CLEAR.
//   Reset mid-CLEAR or mid-ACK: immediate return to the reset state; no partial
//     debug ack.
//   Register 0: never written. Its storage is not required to be implemented.
// TESTING
//   T1 reset; write r5=0xDEADBEEF; next cycle rs_addr0=5 -> rs_data0=0xDEADBEEF;
//      rs_addr1=0 -> 0.
//   T2 BYPASS=1: we=1 rd=7 wd=0x1234 with rs_addr0=7 in the same cycle ->
//      rs_data0=0x1234 before the edge. BYPASS=0 -> old value 0.
//   T3 we=1 rd=0 wd=0xFFFFFFFF -> r0 still reads 0. Debug write r0 -> dbg_rdata=0,
//      r0 stays 0.
//   T4 r3=0xA5; dbg_req dbg_we=1 addr=3 wdata=0x5A -> dbg_ack 1 cycle later,
//      dbg_rdata=0xA5, r3 reads 0x5A. Same edge as core write r3=0x77 -> r3=0x77.
//   T5 fill r1..r31 nonzero; pulse clr_req -> clr_busy high 31 cycles, then all
//      reads 0. A core write during busy is dropped.
//   T6 assert reset at clear cycle 10 -> immediate clr_busy=0 and all registers 0;
//      dbg_req+clr_req in the same IDLE cycle -> CLEAR, no dbg_ack.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-read-port integer register file for the RISC-V datapath.
//
// Register 0 always reads as zero. Besides the core read and write ports, the
// file has a handshaked debug port and a clear engine. The clear engine zeroes
// r1..r(NREGS-1), one register per cycle, without using reset.
//
// Ports
//   clk_i        clock; all state updates on the rising edge
//   rst_i        asynchronous active-high reset
//   rs_addr_i    NUM_RD read addresses; port i = [i*AW +: AW]
//   rs_data_o    NUM_RD combinational read data; port i = [i*XLEN +: XLEN]
//   we_i         core write enable
//   rd_i         core write address
//   wd_i         core write data
//   dbg_req_i    debug access request
//   dbg_we_i     debug access is a write
//   dbg_addr_i   debug register address
//   dbg_wdata_i  debug write data
//   dbg_ack_o    one-cycle acknowledge of an accepted debug access
//   dbg_rdata_o  debug read data (pre-write value), held until the next access
//   clr_req_i    start the clear sequence
//   clr_busy_o   clear in progress; the core must stall
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*AW-1:0]     rs_addr_i,
    output logic [NUM_RD*XLEN-1:0]   rs_data_o,
    input  logic                     we_i,
    input  logic [AW-1:0]            rd_i,
    input  logic [XLEN-1:0]          wd_i,
    input  logic                     dbg_req_i,
    input  logic                     dbg_we_i,
    input  logic [AW-1:0]            dbg_addr_i,
    input  logic [XLEN-1:0]          dbg_wdata_i,
    output logic                     dbg_ack_o,
    output logic [XLEN-1:0]          dbg_rdata_o,
    input  logic                     clr_req_i,
    output logic                     clr_busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
    logic [XLEN-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic [XLEN-1:0]   regs_q [NREGS];

    logic              write_eff;
    logic              dbg_accept;
    logic              dbg_wr_en;

    // Core writes are suppressed while clearing, so that a stalled core cannot
    // leave stale data behind the clear pointer.
    assign write_eff  = we_i && (rd_i != '0) && (state_q != CLEAR);

    // Clear requests take priority over debug requests in IDLE.
    assign dbg_accept = (state_q == IDLE) && !clr_req_i && dbg_req_i;
    assign dbg_wr_en  = dbg_accept && dbg_we_i && (dbg_addr_i != '0);

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data;

            assign addr = rs_addr_i[gi*AW +: AW];

            always_comb begin
                data = regs_q[addr];
                if (addr == '0) begin
                    data = '0;
                end else if ((BYPASS != 0) && write_eff && (rd_i == addr)) begin
                    data = wd_i;
                end
            end

            assign rs_data_o[gi*XLEN +: XLEN] = data;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage. Entry 0 is never written after reset, so it stays zero and
    // can be trimmed away by synthesis.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            regs_q[clr_ptr_q] <= '0;
        end else begin
            if (dbg_wr_en) begin
                regs_q[dbg_addr_i] <= dbg_wdata_i;
            end
            // Issued after the debug write so a core write to the same
            // register on the same edge takes precedence.
            if (write_eff) begin
                regs_q[rd_i] <= wd_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            clr_ptr_q   <= AW'(1);
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        dbg_rdata_d = dbg_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d   = CLEAR;
                    clr_ptr_d = AW'(1);
                end else if (dbg_req_i) begin
                    state_d = ACK;
                    // Raw storage value: debug reads see the pre-write
                    // contents and never the bypassed core write data.
                    dbg_rdata_d = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];
                end
            end
            CLEAR: begin
                if (clr_ptr_q == AW'(NREGS - 1)) begin
                    state_d   = IDLE;
                    clr_ptr_d = AW'(1);
                end else begin
                    clr_ptr_d = clr_ptr_q + AW'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dbg_ack_o   = (state_q == ACK);
    assign dbg_rdata_o = dbg_rdata_q;
    assign clr_busy_o  = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp. Two instances share the stimulus: one with
// write-to-read bypass enabled and one without. The stimulus process pushes
// expected values into queues; the monitor process pops and compares them
// at each falling edge, and checks every debug acknowledge against the
// queue of expected debug read data.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct {
        string       name;
        int          sel;   // 0/1: bypass DUT ports, 2/3: no-bypass ports, 4: clr_busy, 5: dbg_rdata
        logic [31:0] val;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     ra0, ra1;
    logic [2*AW-1:0]   rs_addr;
    logic [2*XLEN-1:0] rs_data, nb_rs_data;
    logic              we;
    logic [AW-1:0]     rd;
    logic [XLEN-1:0]   wd;
    logic              dbg_req, dbg_we;
    logic [AW-1:0]     dbg_addr;
    logic [XLEN-1:0]   dbg_wdata;
    logic              dbg_ack, nb_dbg_ack;
    logic [XLEN-1:0]   dbg_rdata, nb_dbg_rdata;
    logic              clr_req;
    logic              clr_busy, nb_clr_busy;

    int   tests = 0;
    int   fails = 0;
    logic done  = 1'b0;

    exp_t        rd_q[$];
    logic [31:0] dbg_q[$];

    assign rs_addr = {ra1, ra0};

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rs_data_o(rs_data),
        .we_i(we), .rd_i(rd), .wd_i(wd),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata),
        .clr_req_i(clr_req), .clr_busy_o(clr_busy)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(0)) u_nb (
        .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rs_data_o(nb_rs_data),
        .we_i(we), .rd_i(rd), .wd_i(wd),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_ack_o(nb_dbg_ack), .dbg_rdata_o(nb_dbg_rdata),
        .clr_req_i(clr_req), .clr_busy_o(nb_clr_busy)
    );

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (dbg_ack) begin
                tests++;
                if (dbg_q.size() == 0) begin
                    fails++;
                    $display("FAIL dbg_ack: unexpected ack, rdata=%h", dbg_rdata);
                end else begin
                    logic [31:0] e;
                    e = dbg_q.pop_front();
                    if (dbg_rdata !== e) begin
                        fails++;
                        $display("FAIL dbg_rdata: got %h expected %h", dbg_rdata, e);
                    end else begin
                        $display("[TB] dbg ack rdata=%h ok", dbg_rdata);
                    end
                end
            end
            while (rd_q.size() != 0) begin
                exp_t        x;
                logic [31:0] act;
                x = rd_q.pop_front();
                case (x.sel)
                    0:       act = rs_data[31:0];
                    1:       act = rs_data[63:32];
                    2:       act = nb_rs_data[31:0];
                    3:       act = nb_rs_data[63:32];
                    4:       act = {31'd0, clr_busy};
                    default: act = dbg_rdata;
                endcase
                tests++;
                if (act !== x.val) begin
                    fails++;
                    $display("FAIL %s: got %h expected %h", x.name, act, x.val);
                end else begin
                    $display("[TB] %s = %h ok", x.name, act);
                end
            end
            if (done) begin
                tests++;
                if (dbg_q.size() != 0) begin
                    fails++;
                    $display("FAIL dbg_missing_ack: got %0d pending expected 0", dbg_q.size());
                end
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int sel, input logic [31:0] val);
        exp_t x;
        x.name = name;
        x.sel  = sel;
        x.val  = val;
        rd_q.push_back(x);
    endtask

    task automatic core_write(input logic [AW-1:0] a, input logic [31:0] d);
        we = 1'b1; rd = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 1; i < 32; i++) begin
            core_write(AW'(i), 32'h0101_0101 * i);
        end
    endtask

    initial begin
        rst = 1'b1; ra0 = '0; ra1 = '0; we = 1'b0; rd = '0; wd = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; clr_req = 1'b0;
        tick();
        // Reset state
        ra0 = 5'd5; ra1 = 5'd31;
        expect_val("reset_rs0", 0, 32'h0);
        expect_val("reset_rs1", 1, 32'h0);
        expect_val("reset_busy", 4, 32'h0);
        expect_val("reset_dbg_rdata", 5, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // T1: plain write then read
        core_write(5'd5, 32'hDEAD_BEEF);
        ra0 = 5'd5; ra1 = 5'd0;
        expect_val("t1_r5", 0, 32'hDEAD_BEEF);
        expect_val("t1_r0", 1, 32'h0);
        expect_val("t1_nb_r5", 2, 32'hDEAD_BEEF);
        expect_val("t1_nb_r0", 3, 32'h0);
        tick();

        // T2: same-cycle bypass vs. no bypass
        ra0 = 5'd7; we = 1'b1; rd = 5'd7; wd = 32'h1234;
        expect_val("t2_bypass", 0, 32'h1234);
        expect_val("t2_nobypass_old", 2, 32'h0);
        tick();
        we = 1'b0;
        expect_val("t2_after", 0, 32'h1234);
        expect_val("t2_nb_after", 2, 32'h1234);
        tick();

        // T3: writes to r0 are dropped, no bypass of r0
        ra0 = 5'd0; we = 1'b1; rd = 5'd0; wd = 32'hFFFF_FFFF;
        expect_val("t3_r0_bypass", 0, 32'h0);
        tick();
        we = 1'b0;
        expect_val("t3_r0_after", 0, 32'h0);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFFFF_FFFF;
        dbg_q.push_back(32'h0);
        tick();
        dbg_req = 1'b0;
        tick();
        expect_val("t3_r0_dbg", 0, 32'h0);
        tick();

        // T4: debug write returns old value; core write wins a collision
        core_write(5'd3, 32'hA5);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'h5A;
        dbg_q.push_back(32'hA5);
        tick();
        dbg_req = 1'b0; ra0 = 5'd3;
        expect_val("t4_r3_dbgwr", 0, 32'h5A);
        tick();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'hDD;
        we = 1'b1; rd = 5'd3; wd = 32'h77;
        dbg_q.push_back(32'h5A);
        tick();
        dbg_req = 1'b0; we = 1'b0;
        expect_val("t4_r3_core_wins", 0, 32'h77);
        tick();
        // Held request: ACK then a fresh access on the following IDLE cycle
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
        dbg_q.push_back(32'h1234);
        dbg_q.push_back(32'h1234);
        tick(); tick(); tick();
        dbg_req = 1'b0;
        tick();
        dbg_addr = 5'd5;
        expect_val("t4_dbg_rdata_hold", 5, 32'h1234);
        tick();

        // T5: clear engine
        fill_all();
        ra0 = 5'd31; ra1 = 5'd1;
        expect_val("t5_fill_r31", 0, 32'h1F1F_1F1F);
        expect_val("t5_fill_r1", 1, 32'h0101_0101);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        ra0 = 5'd16; ra1 = 5'd31;
        for (int k = 0; k < 31; k++) begin
            we = (k == 0); rd = 5'd31; wd = 32'hFFFF_0000;
            dbg_req = (k == 3); dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h9;
            clr_req = (k == 5);
            expect_val($sformatf("t5_busy_%0d", k), 4, 32'h1);
            expect_val($sformatf("t5_r16_%0d", k), 0, (k >= 16) ? 32'h0 : 32'h1010_1010);
            expect_val($sformatf("t5_r31_%0d", k), 1, 32'h1F1F_1F1F);
            tick();
        end
        we = 1'b0; dbg_req = 1'b0; clr_req = 1'b0;
        expect_val("t5_busy_done", 4, 32'h0);
        expect_val("t5_r31_cleared", 1, 32'h0);
        for (int a = 1; a < 32; a++) begin
            ra0 = AW'(a);
            expect_val($sformatf("t5_zero_r%0d", a), 0, 32'h0);
            tick();
        end

        // T6: reset in the middle of a clear
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1; ra0 = 5'd31; ra1 = 5'd20;
        expect_val("t6_rst_busy", 4, 32'h0);
        expect_val("t6_rst_r31", 0, 32'h0);
        expect_val("t6_rst_r20", 1, 32'h0);
        tick();
        rst = 1'b0;
        core_write(5'd4, 32'h99);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'h44; clr_req = 1'b1;
        tick();
        dbg_req = 1'b0; clr_req = 1'b0;
        expect_val("t6_clr_priority_busy", 4, 32'h1);
        tick();
        begin
            int n;
            n = 0;
            while (clr_busy && n < 40) begin
                tick();
                n++;
            end
            if (n >= 40) begin
                expect_val("t6_busy_timeout", 4, 32'h0);
            end
        end
        ra0 = 5'd4;
        expect_val("t6_r4_cleared", 0, 32'h0);
        tick();
        tick();
        done = 1'b1;
    end

endmodule
